// File: rtl/modulus_counter_arbiter.sv
// Round-robin arbiter sharing one programmable-modulus counter among 4 requesters.
// Latency: grant/owner/busy/Q valid 1 cycle after req is sampled; done is decoded from registers only.
// Backpressure: a requester drops req to abort its run; there is no stall path, the counter steps every RUN cycle.
//
// Ports: clk, reset_n (async active-low), req[3:0] level requests,
//        limit[4*n-1:0] per-requester terminal values, grant[3:0] one-hot owner,
//        owner[1:0] owner index, busy, Q shared counter, done[3:0] terminal strobe.
module modulus_counter_arbiter #(
  parameter int n = 3
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [3:0]     req,
  input  logic [4*n-1:0] limit,
  output logic [3:0]     grant,
  output logic [1:0]     owner,
  output logic           busy,
  output logic [n-1:0]   Q,
  output logic [3:0]     done
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t       r_state, w_state_nxt;
  logic [3:0]   r_grant, w_grant_nxt;
  logic [1:0]   r_owner, w_owner_nxt;
  logic [1:0]   r_ptr,   w_ptr_nxt;
  logic [n-1:0] r_q,     w_q_nxt;
  logic [n-1:0] r_lim,   w_lim_nxt;

  logic         w_at_lim;
  logic         w_end;
  logic [1:0]   w_search_ptr;
  logic [7:0]   w_req2;
  logic [3:0]   w_rot;
  logic [1:0]   w_off;
  logic         w_win_vld;
  logic [1:0]   w_win_idx;
  logic [n-1:0] w_win_lim;

  assign w_at_lim = (r_q == r_lim);
  // A run ends on its terminal count or when the owner withdraws its request.
  assign w_end    = (r_state == ST_RUN) && (w_at_lim || !req[r_owner]);

  // At the end of a run the search already starts one past the owner, so the
  // hand-off uses the pointer value that is being written on this same edge.
  assign w_search_ptr = (r_state == ST_RUN) ? r_owner + 2'd1 : r_ptr;

  // Rotate req so the search start lands at bit 0, then pick the lowest set bit.
  assign w_req2 = {req, req};
  assign w_rot  = w_req2[w_search_ptr +: 4];

  always_comb begin
    w_off     = 2'd3;
    w_win_vld = |w_rot;
    if (w_rot[0])      w_off = 2'd0;
    else if (w_rot[1]) w_off = 2'd1;
    else if (w_rot[2]) w_off = 2'd2;
  end

  assign w_win_idx = w_search_ptr + w_off;
  assign w_win_lim = limit[w_win_idx*n +: n];

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_q_nxt     = r_q;
    w_lim_nxt   = r_lim;
    case (r_state)
      ST_IDLE: begin
        if (w_win_vld) begin
          w_state_nxt = ST_RUN;
          w_grant_nxt = 4'b0001 << w_win_idx;
          w_owner_nxt = w_win_idx;
          w_lim_nxt   = w_win_lim;
          w_q_nxt     = '0;
        end
      end
      ST_RUN: begin
        if (w_end) begin
          w_q_nxt   = '0;
          w_ptr_nxt = r_owner + 2'd1;
          if (w_win_vld) begin
            // Back-to-back hand-off: stay in RUN with the new owner.
            w_grant_nxt = 4'b0001 << w_win_idx;
            w_owner_nxt = w_win_idx;
            w_lim_nxt   = w_win_lim;
          end else begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = '0;
            w_owner_nxt = '0;
          end
        end else begin
          w_q_nxt = r_q + n'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
      r_q     <= '0;
      r_lim   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_q     <= w_q_nxt;
      r_lim   <= w_lim_nxt;
    end
  end

  assign grant = r_grant;
  assign owner = r_owner;
  assign busy  = (r_state == ST_RUN);
  assign Q     = r_q;
  // The owner's strobe coincides with Q==lim_r, so grant and done always agree.
  assign done  = (busy && w_at_lim) ? r_grant : 4'b0000;

endmodule

// File: tb/tb_modulus_counter_arbiter.sv
// Self-checking bench for modulus_counter_arbiter (n=3).
// Latency: model predicts outputs after each rising edge; DUT sampled on the falling edge.
// Backpressure: exercised through req drop (abort) and held-high re-requests.
module tb_modulus_counter_arbiter;
  localparam int N = 3;

  logic           clk;
  logic           reset_n;
  logic [3:0]     req;
  logic [4*N-1:0] limit;
  logic [3:0]     grant;
  logic [1:0]     owner;
  logic           busy;
  logic [N-1:0]   Q;
  logic [3:0]     done;

  modulus_counter_arbiter #(.n(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .limit   (limit),
    .grant   (grant),
    .owner   (owner),
    .busy    (busy),
    .Q       (Q),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a run is described by who owns it, its length and how far it has got.
  int m_busy;
  int m_owner;
  int m_lim;
  int m_q;
  int m_ptr;
  int m_done_seen [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [4*N-1:0] mk_lim(input int l0, input int l1, input int l2, input int l3);
    logic [N-1:0] a, b, c, d;
    a = N'(l0); b = N'(l1); c = N'(l2); d = N'(l3);
    return {d, c, b, a};
  endfunction

  function automatic int pick(input int p, input logic [3:0] rq);
    for (int k = 0; k < 4; k++)
      if (rq[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_lim = 0; m_q = 0; m_ptr = 0;
  endtask

  task automatic start_run(input int w, input logic [4*N-1:0] lm);
    logic [4*N-1:0] t;
    t = lm >> (w * N);
    m_busy  = 1;
    m_owner = w;
    m_lim   = int'(t[N-1:0]);
    m_q     = 0;
  endtask

  // Advance the model across one rising edge with the given inputs.
  task automatic model_step(input logic [3:0] rq, input logic [4*N-1:0] lm);
    int w;
    if (m_busy == 0) begin
      w = pick(m_ptr, rq);
      if (w >= 0) start_run(w, lm);
    end else if (m_q == m_lim || !rq[m_owner]) begin
      m_ptr = (m_owner + 1) % 4;
      w = pick(m_ptr, rq);
      if (w >= 0) start_run(w, lm);
      else begin
        m_busy = 0; m_owner = 0; m_q = 0;
      end
    end else begin
      m_q = m_q + 1;
    end
  endtask

  task automatic check_outputs();
    logic [3:0] eg, ed;
    eg = (m_busy != 0) ? (4'b0001 << m_owner) : 4'b0000;
    ed = (m_busy != 0 && m_q == m_lim) ? eg : 4'b0000;
    check("grant", 32'(grant), 32'(eg));
    check("owner", 32'(owner), 32'(m_owner));
    check("busy",  32'(busy),  32'(m_busy));
    check("Q",     32'(Q),     32'(m_q));
    check("done",  32'(done),  32'(ed));
    for (int i = 0; i < 4; i++) if (ed[i]) m_done_seen[i]++;
  endtask

  task automatic cyc(input logic [3:0] rq, input logic [4*N-1:0] lm);
    @(negedge clk);
    check_outputs();
    req   = rq;
    limit = lm;
    model_step(rq, lm);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic async_reset();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    req     = 4'b0000;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [3:0] rq;
    logic [4*N-1:0] lm;
    int guard;
    reset_n = 1'b1;
    req     = '0;
    limit   = '0;
    for (int i = 0; i < 4; i++) m_done_seen[i] = 0;
    #1 reset_n = 1'b0;
    model_reset();
    #12;
    check_outputs();
    @(negedge clk);
    reset_n = 1'b1;

    // Single run of requester 0, limit 3, then release.
    cyc(4'b0001, mk_lim(3, 0, 0, 0));
    repeat (4) cyc(4'b0001, mk_lim(3, 0, 0, 0));
    repeat (3) cyc(4'b0000, mk_lim(3, 0, 0, 0));
    check("done_count_r0", 32'(m_done_seen[0]), 32'd1);

    // All requesting with limit 1: rotation with no idle gap.
    repeat (18) cyc(4'b1111, mk_lim(1, 1, 1, 1));
    repeat (3) cyc(4'b0000, mk_lim(1, 1, 1, 1));

    // Limit 0 then full limit on requester 2.
    cyc(4'b0100, mk_lim(0, 0, 0, 0));
    repeat (2) cyc(4'b0000, mk_lim(0, 0, 0, 0));
    repeat (10) cyc(4'b0100, mk_lim(0, 0, 7, 0));
    repeat (3) cyc(4'b0000, mk_lim(0, 0, 7, 0));

    // Limit changed mid-run is ignored.
    cyc(4'b0001, mk_lim(2, 0, 0, 0));
    repeat (4) cyc(4'b0001, mk_lim(5, 0, 0, 0));
    repeat (3) cyc(4'b0000, mk_lim(5, 0, 0, 0));

    // Async reset mid-run at Q=4.
    cyc(4'b0001, mk_lim(7, 0, 0, 0));
    guard = 0;
    while (m_q != 4 && guard < 20) begin
      cyc(4'b0001, mk_lim(7, 0, 0, 0));
      guard++;
    end
    check("reach_q4", 32'(m_q), 32'd4);
    async_reset();

    // Abort requester 1 at Q=2 with requester 3 pending.
    cyc(4'b0010, mk_lim(0, 6, 0, 3));
    guard = 0;
    while (m_q != 2 && guard < 20) begin
      cyc(4'b1010, mk_lim(0, 6, 0, 3));
      guard++;
    end
    check("reach_q2", 32'(m_q), 32'd2);
    repeat (6) cyc(4'b1000, mk_lim(0, 6, 0, 3));
    repeat (2) cyc(4'b0000, mk_lim(0, 6, 0, 3));
    check("done_count_r1", 32'(m_done_seen[1]), 32'd3);

    // Randomized traffic: sticky requests with occasional drops, changing limits.
    rq = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 5) == 0) rq[b] = ~rq[b];
      lm = (4*N)'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        async_reset();
        rq = 4'b0000;
      end
      cyc(rq, lm);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
